// File: rtl/uart_tx.sv
// UART transmitter: start bit, DBIT data bits LSB first, stop bit, paced by the
// 16x oversampling tick shared with the receiver. One frame in flight at a time.
module uart_tx #(
    parameter int DBIT      = 8,
    parameter int NUM_TICKS = 16,
    parameter int SB_TICK   = 16
) (
    input  logic            CLK,
    input  logic            reset,
    input  logic            TICK,
    input  logic            TX_START,
    input  logic [DBIT-1:0] D_IN,
    output logic            TX,
    output logic            BUSY,
    output logic            TX_DONE
);

    localparam int S_MAX = (NUM_TICKS > SB_TICK) ? NUM_TICKS : SB_TICK;
    localparam int SW    = ($clog2(S_MAX) > 0) ? $clog2(S_MAX) : 1;
    localparam int NW    = ($clog2(DBIT) > 0) ? $clog2(DBIT) : 1;

    localparam logic [SW-1:0] S_BIT_LAST  = SW'(NUM_TICKS - 1);
    localparam logic [SW-1:0] S_STOP_LAST = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST      = NW'(DBIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t          state;
    logic [SW-1:0]   s;
    logic [NW-1:0]   n;
    logic [DBIT-1:0] shreg;

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            s       <= '0;
            n       <= '0;
            shreg   <= '0;
            TX      <= 1'b1;
            BUSY    <= 1'b0;
            TX_DONE <= 1'b0;
        end else begin
            TX_DONE <= 1'b0;
            case (state)
                IDLE: begin
                    TX <= 1'b1;
                    if (TX_START) begin
                        shreg <= D_IN;
                        s     <= '0;
                        state <= START;
                        TX    <= 1'b0;
                        BUSY  <= 1'b1;
                    end
                end
                START: begin
                    if (TICK) begin
                        if (s == S_BIT_LAST) begin
                            s     <= '0;
                            n     <= '0;
                            state <= DATA;
                            TX    <= shreg[0];
                        end else begin
                            s <= s + SW'(1);
                        end
                    end
                end
                DATA: begin
                    if (TICK) begin
                        if (s == S_BIT_LAST) begin
                            s     <= '0;
                            shreg <= shreg >> 1;
                            // TX registers the bit that will sit in shreg[0] after this shift
                            if (n == N_LAST) begin
                                state <= STOP;
                                TX    <= 1'b1;
                            end else begin
                                n  <= n + NW'(1);
                                TX <= shreg[1];
                            end
                        end else begin
                            s <= s + SW'(1);
                        end
                    end
                end
                STOP: begin
                    if (TICK) begin
                        if (s == S_STOP_LAST) begin
                            s       <= '0;
                            state   <= IDLE;
                            BUSY    <= 1'b0;
                            TX_DONE <= 1'b1;
                        end else begin
                            s <= s + SW'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    TX    <= 1'b1;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: frame-level model (bit index = ticks consumed / 16) compared
// every cycle, plus directed frames decoded from the line and checked against literals.
module tb_uart_tx;

    localparam int NT          = 16;
    localparam int SB          = 16;
    localparam int NBITS       = 8;
    localparam int DATA_END    = (1 + NBITS) * NT;
    localparam int FRAME_TICKS = DATA_END + SB;

    logic       CLK = 1'b0;
    logic       reset = 1'b0;
    logic       TICK = 1'b0;
    logic       TX_START = 1'b0;
    logic [7:0] D_IN = 8'h00;
    logic       TX;
    logic       BUSY;
    logic       TX_DONE;

    int n_checks = 0;
    int n_pass   = 0;
    logic chk_en = 1'b0;
    logic tick_en = 1'b1;

    uart_tx #(
        .DBIT(NBITS),
        .NUM_TICKS(NT),
        .SB_TICK(SB)
    ) dut (
        .CLK(CLK),
        .reset(reset),
        .TICK(TICK),
        .TX_START(TX_START),
        .D_IN(D_IN),
        .TX(TX),
        .BUSY(BUSY),
        .TX_DONE(TX_DONE)
    );

    always #5 CLK = ~CLK;

    initial begin
        int tc;
        tc = 0;
        forever begin
            @(posedge CLK);
            #2;
            if (tick_en) begin
                TICK = (tc == 3);
                tc = (tc + 1) % 4;
            end else begin
                TICK = 1'b0;
            end
        end
    end

    // Frame model: a frame is a 9-entry bit list (start + data), then a stop bit;
    // the line level follows from how many ticks have been consumed since accept.
    logic       m_busy = 1'b0;
    logic       m_done = 1'b0;
    int         m_t = 0;
    logic [8:0] m_bits = '1;

    always @(posedge CLK or negedge reset) begin
        if (!reset) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_t    <= 0;
        end else begin
            m_done <= 1'b0;
            if (!m_busy) begin
                if (TX_START) begin
                    m_busy <= 1'b1;
                    m_t    <= 0;
                    m_bits <= {D_IN, 1'b0};
                end
            end else if (TICK) begin
                if (m_t + 1 == FRAME_TICKS) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                end else begin
                    m_t <= m_t + 1;
                end
            end
        end
    end

    function automatic logic exp_tx();
        if (!m_busy) return 1'b1;
        if (m_t < DATA_END) return m_bits[m_t / NT];
        return 1'b1;
    endfunction

    int   tick_count = 0;
    int   done_cnt = 0;
    int   rise_t = 0;
    int   high_ticks = 0;
    logic tx_prev = 1'b1;

    always @(posedge CLK) if (TICK) tick_count <= tick_count + 1;

    always @(negedge CLK) begin
        tx_prev <= TX;
        if (TX_DONE) done_cnt <= done_cnt + 1;
        if (TX && !tx_prev) rise_t <= tick_count;
        if (!TX && tx_prev) high_ticks <= tick_count - rise_t;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    initial begin
        forever begin
            @(negedge CLK);
            if (chk_en) begin
                chk("model_tx", {31'd0, TX}, {31'd0, exp_tx()});
                chk("model_busy", {31'd0, BUSY}, {31'd0, m_busy});
                chk("model_done", {31'd0, TX_DONE}, {31'd0, m_done});
            end
        end
    end

    task automatic send(input logic [7:0] d);
        @(posedge CLK);
        #2;
        TX_START = 1'b1;
        D_IN = d;
        @(posedge CLK);
        #2;
        TX_START = 1'b0;
    endtask

    task automatic decode(output logic [7:0] b, output logic stop);
        int k;
        k = 0;
        b = 8'h00;
        stop = 1'b0;
        while (TX !== 1'b0 && k < 3000) begin
            @(negedge CLK);
            k++;
        end
        if (TX !== 1'b0) begin
            chk("start_timeout", {31'd0, TX}, 32'd0);
            return;
        end
        repeat (32) @(negedge CLK);
        chk("start_bit", {31'd0, TX}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            repeat (64) @(negedge CLK);
            b[i] = TX;
        end
        repeat (64) @(negedge CLK);
        stop = TX;
    endtask

    task automatic wait_done(output int ticks_at_done);
        int k;
        k = 0;
        ticks_at_done = 0;
        while (TX_DONE !== 1'b1 && k < 1000) begin
            @(negedge CLK);
            k++;
        end
        chk("done_seen", {31'd0, TX_DONE}, 32'd1);
        ticks_at_done = tick_count;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (BUSY !== 1'b0 && k < 3000) begin
            @(negedge CLK);
            k++;
        end
        chk("idle_timeout", {31'd0, BUSY}, 32'd0);
    endtask

    initial begin
        logic [7:0] b;
        logic       stop;
        int         acc_t;
        int         done_t;
        int         d0;
        logic       ok;
        int         k;

        // 1: reset held with TX_START high
        TX_START = 1'b1;
        D_IN = 8'h5A;
        @(posedge CLK);
        chk_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            chk("rst_tx", {31'd0, TX}, 32'd1);
            chk("rst_busy", {31'd0, BUSY}, 32'd0);
            chk("rst_done", {31'd0, TX_DONE}, 32'd0);
        end
        @(posedge CLK);
        #2;
        TX_START = 1'b0;
        reset = 1'b1;
        repeat (10) @(negedge CLK);
        chk("idle_after_rst", {30'd0, TX, BUSY}, 32'd2);

        // 2: 0xA5 frame, 160 ticks accept-to-done
        d0 = done_cnt;
        send(8'hA5);
        acc_t = tick_count;
        decode(b, stop);
        chk("a5_byte", {24'd0, b}, 32'hA5);
        chk("a5_stop", {31'd0, stop}, 32'd1);
        wait_done(done_t);
        chk("frame_ticks", done_t - acc_t, FRAME_TICKS);
        chk("busy_falls_with_done", {31'd0, BUSY}, 32'd0);
        repeat (20) @(negedge CLK);
        chk("a5_done_count", done_cnt - d0, 32'd1);

        // 3: TX_START during DATA (bit 3) ignored
        d0 = done_cnt;
        send(8'hA5);
        fork
            decode(b, stop);
            begin
                repeat (4 * 64 + 16) @(posedge CLK);
                #2;
                TX_START = 1'b1;
                D_IN = 8'hFF;
                repeat (4) @(posedge CLK);
                #2;
                TX_START = 1'b0;
            end
        join
        chk("mid_start_byte", {24'd0, b}, 32'hA5);
        wait_idle();
        repeat (20) @(negedge CLK);
        chk("mid_start_done_count", done_cnt - d0, 32'd1);

        // 4: reset during DATA, then a clean 0x00 frame
        send(8'h00);
        repeat (3 * 64) @(posedge CLK);
        #2;
        chk("pre_reset_low", {31'd0, TX}, 32'd0);
        reset = 1'b0;
        #1;
        chk("reset_tx_now", {31'd0, TX}, 32'd1);
        chk("reset_busy_now", {31'd0, BUSY}, 32'd0);
        repeat (3) @(posedge CLK);
        #2;
        reset = 1'b1;
        repeat (5) @(negedge CLK);
        d0 = done_cnt;
        send(8'h00);
        decode(b, stop);
        chk("post_reset_byte", {24'd0, b}, 32'h00);
        chk("post_reset_stop", {31'd0, stop}, 32'd1);
        wait_idle();
        repeat (5) @(negedge CLK);
        chk("post_reset_done_count", done_cnt - d0, 32'd1);

        // 5: TX_START held high -> back-to-back frames
        @(posedge CLK);
        #2;
        TX_START = 1'b1;
        D_IN = 8'h00;
        k = 0;
        while (BUSY !== 1'b1 && k < 10) begin
            @(negedge CLK);
            k++;
        end
        chk("b2b_accept", {31'd0, BUSY}, 32'd1);
        @(posedge CLK);
        #2;
        D_IN = 8'hFF;
        decode(b, stop);
        chk("b2b_byte0", {24'd0, b}, 32'h00);
        wait_done(done_t);
        chk("b2b_tx_high_at_done", {31'd0, TX}, 32'd1);
        @(negedge CLK);
        #1;
        chk("b2b_second_start", {31'd0, TX}, 32'd0);
        chk("b2b_stop_ticks", high_ticks, 32'd16);
        @(posedge CLK);
        #2;
        TX_START = 1'b0;
        decode(b, stop);
        chk("b2b_byte1", {24'd0, b}, 32'hFF);
        chk("b2b_stop1", {31'd0, stop}, 32'd1);
        wait_idle();

        // 6: TICK stalled after accept
        repeat (5) @(negedge CLK);
        @(posedge CLK);
        #2;
        tick_en = 1'b0;
        send(8'h5A);
        ok = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge CLK);
            if (BUSY !== 1'b1 || TX !== 1'b0) ok = 1'b0;
        end
        chk("stall_hold", {31'd0, ok}, 32'd1);
        @(posedge CLK);
        #2;
        tick_en = 1'b1;
        decode(b, stop);
        chk("stall_byte", {24'd0, b}, 32'h5A);
        chk("stall_stop", {31'd0, stop}, 32'd1);
        wait_idle();
        repeat (5) @(negedge CLK);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
